fmul_issue: RTL and testbench

- Issue/writeback stage wrapped around the FPU multiplier (`fmul`). It accepts tagged multiply requests over a valid/ready handshake and conditions operands to meet `fmul`'s input contract (x1 normal, x2 possibly subnormal).
- `fmul` has one cycle of latency and no stall. This block absorbs its results into a tagged output FIFO with backpressure.
- Sits between the FPU dispatch logic and the FP register-file writeback arbiter.

---
 rtl/fmul_issue.sv | 144 ++++++++++++++
 tb/tb_fmul_issue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_issue.sv
// fmul_issue: issue/writeback wrapper around the single-cycle fmul multiplier.
// Requests arrive over valid/ready. Operands are swapped when needed so that
// fmul sees a normal x1. Each result is pushed with its tag into an output
// FIFO. Admission is credit-based, so an in-flight op always has a free slot
// waiting for it.

module fmul_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mul_x1,
  output logic [31:0]      mul_x2,
  input  logic [31:0]      mul_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic             r_inflight;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_mem_y   [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];

  logic             w_swap;
  logic [CW-1:0]    w_used;
  logic             w_fire;
  logic             w_push;
  logic             w_pop;

  // Swap only when x1 is zero/subnormal and x2 is normal; both-subnormal passes through.
  assign w_swap = (in_x1[30:23] == 8'd0) && (in_x2[30:23] != 8'd0);

  // Operand steering to fmul follows the inputs every cycle.
  always_comb begin
    mul_x1 = in_x1;
    mul_x2 = in_x2;
    if (w_swap) begin
      mul_x1 = in_x2;
      mul_x2 = in_x1;
    end else begin
      mul_x1 = in_x1;
      mul_x2 = in_x2;
    end
  end

  // Slots already promised: buffered results plus the one still inside fmul.
  assign w_used    = r_count + {{(CW-1){1'b0}}, r_inflight};
  assign in_ready  = !flush && (w_used < CW'(DEPTH));
  assign w_fire    = in_valid && in_ready;
  assign w_push    = r_inflight && !flush;
  assign out_valid = (r_count != {CW{1'b0}});
  assign w_pop     = out_valid && out_ready && !flush;
  assign out_y     = r_mem_y[r_rd_ptr];
  assign out_tag   = r_mem_tag[r_rd_ptr];
  assign busy      = r_inflight || (r_count != {CW{1'b0}});

  // Pipeline tracking, FIFO pointers and occupancy; flush empties everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count    <= {CW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_wr_ptr   <= {PW{1'b0}};
      r_inflight <= 1'b0;
      r_tag      <= {TAG_W{1'b0}};
    end else if (flush) begin
      r_count    <= {CW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_wr_ptr   <= {PW{1'b0}};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_fire;
      if (w_fire) begin
        r_tag <= in_tag;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result storage; contents are left stale across a flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_y[i]   <= 32'd0;
        r_mem_tag[i] <= {TAG_W{1'b0}};
      end
    end else if (w_push) begin
      r_mem_y[r_wr_ptr]   <= mul_y;
      r_mem_tag[r_wr_ptr] <= r_tag;
    end
  end

  fmul_issue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk     (clk),
    .rstn    (rstn),
    .push    (w_push),
    .count   (r_count)
  );

endmodule

// fmul_issue_chk: a result must never be pushed into a full FIFO.
module fmul_issue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rstn,
  input logic          push,
  input logic [CW-1:0] count
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_fmul_issue.sv
// tb_fmul_issue: directed bench with a queue-based reference model and a
// simple single-cycle fmul stand-in.

module tb_fmul_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_x1 = 32'd0;
  logic [31:0]      in_x2 = 32'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      mul_y = 32'd0;
  logic [31:0]      mul_x1, mul_x2, out_y;
  logic [TAG_W-1:0] out_tag;
  logic             in_ready, out_valid, busy;

  int vectors = 0;
  int miscompares = 0;
  int n_acc = 0;
  int stalls = 0;
  logic done_r = 1'b0;
  logic [TAG_W-1:0] popped[$];

  // model state
  ent_t        mq[$];
  logic        m_infl = 1'b0;
  ent_t        m_pend;
  int          m_used;
  logic        m_fire;
  logic [63:0] m_sw;

  always #5 clk = ~clk;

  fmul_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .busy(busy)
  );

  // Truncating single-precision multiply, good enough as an fmul stand-in.
  function automatic logic [31:0] fmul_fn(input logic [31:0] a, input logic [31:0] b);
    logic [9:0]  e;
    logic [47:0] m;
    logic [22:0] f;
    m = {24'd0, (a[30:23] != 8'd0), a[22:0]} * {24'd0, (b[30:23] != 8'd0), b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (m[47]) begin
      e = e + 10'd1;
      f = m[46:24];
    end else begin
      f = m[45:23];
    end
    return {a[31] ^ b[31], e[7:0], f};
  endfunction

  function automatic logic [63:0] swapped(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'd0 && b[30:23] != 8'd0) return {b, a};
    return {a, b};
  endfunction

  function automatic logic [31:0] opa(input int i);
    return 32'h3F80_0000 + 32'(i << 17);
  endfunction

  function automatic logic [31:0] opb(input int i);
    return 32'h4040_0000 + 32'(i << 13);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // fmul stand-in: registered result, one cycle after operands.
  always @(posedge clk) mul_y <= fmul_fn(mul_x1, mul_x2);

  // Reference model: queue of promised results plus one op inside fmul.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_infl = 1'b0;
    end else begin
      m_used = mq.size() + int'(m_infl);
      m_fire = in_valid && !flush && (m_used < DEPTH);
      if (flush) begin
        mq.delete();
        m_infl = 1'b0;
      end else begin
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_pend);
        m_infl = m_fire;
        m_sw = swapped(in_x1, in_x2);
        m_pend.y = fmul_fn(m_sw[63:32], m_sw[31:0]);
        m_pend.tag = in_tag;
      end
    end
  end

  // Observed handshakes.
  always @(posedge clk) begin
    if (rstn && !flush && out_valid && out_ready) popped.push_back(out_tag);
    if (rstn && in_valid && in_ready) n_acc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("mul_x", {mul_x1, mul_x2}, swapped(in_x1, in_x2));
    check("in_ready", 64'(in_ready), 64'(!flush && (mq.size() + int'(m_infl) < DEPTH)));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("busy", 64'(busy), 64'(m_infl || mq.size() != 0));
    if (mq.size() != 0) check("head", 64'({out_y, out_tag}), 64'({mq[0].y, mq[0].tag}));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_x1 = a;
    in_x2 = b;
    in_tag = t;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) stalls++;
      n++;
      if (!acc && n > 200) begin
        check("send_timeout", 64'(0), 64'(1));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_order(input string name, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < popped.size()) check(name, 64'(popped[i]), 64'(first + i));
      else check(name, 64'hFFFF, 64'(first + i));
    end
    check({name, "_count"}, 64'(popped.size()), 64'(n));
  endtask

  initial begin
    // reset state
    tick(2);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_y", 64'(out_y), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rstn = 1'b1;
    tick(1);

    // pin the model helpers
    check("lit_fmul", 64'(fmul_fn(32'h3F80_0000, 32'h4000_0000)), 64'h4000_0000);
    check("lit_swap", swapped(32'h0040_0000, 32'h3F80_0000), 64'h3F80_0000_0040_0000);

    // basic op
    out_ready = 1'b1;
    send(32'h3F80_0000, 32'h4000_0000, 5'd3);
    check("basic_lat0_valid", 64'(out_valid), 64'(0));
    check("basic_lat0_busy", 64'(busy), 64'(1));
    tick(1);
    check("basic_valid", 64'(out_valid), 64'(1));
    check("basic_y", 64'(out_y), 64'h4000_0000);
    check("basic_tag", 64'(out_tag), 64'(3));
    tick(1);
    check("basic_idle", 64'(busy), 64'(0));

    // combinational swap
    in_x1 = 32'h0040_0000;
    in_x2 = 32'h3F80_0000;
    #1;
    check("swap_x1", 64'(mul_x1), 64'h3F80_0000);
    check("swap_x2", 64'(mul_x2), 64'h0040_0000);
    in_x1 = 32'h0000_0001;
    in_x2 = 32'h0000_0002;
    #1;
    check("noswap_x1", 64'(mul_x1), 64'h0000_0001);
    check("noswap_x2", 64'(mul_x2), 64'h0000_0002);
    tick(1);

    // backpressure
    out_ready = 1'b0;
    popped.delete();
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(opa(i), opb(i), 5'(i));
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        check("bp_accepts", 64'(n_acc), 64'(4));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
      end
    join
    tick(4);
    check_order("bp_order", 0, 6);

    // streaming
    popped.delete();
    stalls = 0;
    for (int i = 0; i < 16; i++) send(opa(i + 8), opb(i), 5'(i));
    tick(3);
    check("stream_stalls", 64'(stalls), 64'(0));
    check_order("stream_order", 0, 16);

    // random out_ready
    popped.delete();
    done_r = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(opb(i), opa(i), 5'(i));
        done_r = 1'b1;
      end
      begin
        while (!done_r) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    tick(8);
    check_order("rand_order", 0, 20);

    // flush with two buffered and tag 7 in flight
    out_ready = 1'b0;
    send(opa(1), opb(1), 5'd1);
    send(opa(2), opb(2), 5'd2);
    send(opa(7), opb(7), 5'd7);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'(0));
    tick(1);
    flush = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_in_ready_after", 64'(in_ready), 64'(1));
    popped.delete();
    out_ready = 1'b1;
    tick(4);
    check("flush_no_output", 64'(popped.size()), 64'(0));

    // async reset with three buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(opa(i), opb(i), 5'(i + 10));
    tick(1);
    check("pre_rst_busy", 64'(busy), 64'(1));
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    tick(1);
    rstn = 1'b1;
    out_ready = 1'b1;
    send(32'h3F80_0000, 32'h4000_0000, 5'd9);
    tick(1);
    check("post_rst_y", 64'(out_y), 64'h4000_0000);
    check("post_rst_tag", 64'(out_tag), 64'(9));
    tick(2);
    check("post_rst_idle", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
